// File: rtl/conv_window_mac_pkg.sv
// Shared types and arithmetic helpers for the convolution MAC engine.
// Contents:
//   state_t  - engine control states
//   sat_fn   - clamp a wide exact sum to the signed/unsigned range of a w-bit result
//   relu_fn  - zero a w-bit two's complement value when it is negative
package conv_window_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUT,
    DONE
  } state_t;

  // The sum arrives as an exact 66-bit signed value so neither signed nor
  // unsigned operands up to 64 bits can overflow before the clamp.
  function automatic logic [63:0] sat_fn(input logic signed [65:0] sum,
                                         input int unsigned w,
                                         input logic is_signed);
    logic signed [65:0] hi;
    logic signed [65:0] lo;
    if (is_signed) begin
      hi = (66'sd1 <<< (w - 1)) - 66'sd1;
      lo = -(66'sd1 <<< (w - 1));
    end else begin
      hi = (66'sd1 <<< w) - 66'sd1;
      lo = '0;
    end
    if (sum > hi) return hi[63:0];
    if (sum < lo) return lo[63:0];
    return sum[63:0];
  endfunction

  function automatic logic [63:0] relu_fn(input logic [63:0] x,
                                          input int unsigned w);
    if (((x >> (w - 1)) & 64'd1) != 64'd0) return '0;
    return x;
  endfunction

endpackage

// File: rtl/conv_window_mac_if.sv
// Stream bundle for the convolution MAC engine.
//   in_valid/in_ready/in_pixel/in_weight : (pixel, weight) pair input stream
//   out_valid/out_ready/out_data/out_last: window result output stream
// master = producer of pairs / consumer of results, slave = the engine.
interface conv_window_mac_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pixel;
  logic [DATA_W-1:0] in_weight;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_last;

  modport master (
    output in_valid, in_pixel, in_weight, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_pixel, in_weight, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_window_mac_mac_unit.sv
// Two-stage multiply-accumulate datapath.
// Stage 1 registers pixel*weight when mul_en is high; stage 2 adds the
// registered product (sign- or zero-extended) into the accumulator, either
// clamping or wrapping. clear empties both stages.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   clear           zero accumulator and drop any pending product
//   mul_en          capture a new product this cycle
//   pixel, weight   operands
//   acc             accumulator value
//   pending         a product is waiting to be added
module mac_unit
  import conv_window_mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              mul_en,
  input  logic [DATA_W-1:0] pixel,
  input  logic [DATA_W-1:0] weight,
  output logic [ACC_W-1:0]  acc,
  output logic              pending
);

  logic [2*DATA_W-1:0] prod;
  logic signed [65:0]  acc_x;
  logic signed [65:0]  prod_x;
  logic [ACC_W-1:0]    acc_next;

  // Widen both addends exactly so the clamp sees the true sum.
  always_comb begin
    if (SIGNED != 0) begin
      acc_x  = 66'($signed(acc));
      prod_x = 66'($signed(prod));
    end else begin
      acc_x  = 66'(acc);
      prod_x = 66'(prod);
    end
    if (SAT != 0)
      acc_next = ACC_W'(sat_fn(acc_x + prod_x, int'(ACC_W), SIGNED != 0));
    else
      acc_next = acc + prod_x[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod    <= '0;
      pending <= 1'b0;
      acc     <= '0;
    end else if (clear) begin
      prod    <= '0;
      pending <= 1'b0;
      acc     <= '0;
    end else begin
      pending <= mul_en;
      if (mul_en) begin
        if (SIGNED != 0) prod <= $signed(pixel) * $signed(weight);
        else             prod <= pixel * weight;
      end
      if (pending) acc <= acc_next;
    end
  end

endmodule

// File: rtl/conv_window_mac.sv
// Convolution MAC engine: accumulates TAPS (pixel, weight) products per
// window and hands off one post-processed result per window, stopping after
// NUM_OUT windows.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   start        begin a run (honoured only in IDLE or DONE)
//   bus          slave side of the pair-in / result-out streams
//   out_count    results handed off this run
//   busy         run in progress (ACCUM, DRAIN, OUT)
//   done         high from the final handoff until the next start
module conv_window_mac
  import conv_window_mac_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int TAPS    = 9,
  parameter int NUM_OUT = 72,
  parameter int SIGNED  = 1,
  parameter int SAT     = 1,
  parameter int RELU    = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  conv_window_mac_if.slave             bus,
  output logic [$clog2(NUM_OUT+1)-1:0] out_count,
  output logic                         busy,
  output logic                         done
);

  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CNT_W = $clog2(NUM_OUT + 1);

  state_t             state;
  logic [TAP_W-1:0]   tap_count;
  logic               accept;
  logic               handoff;
  logic               mac_clear;
  logic               pending;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   post_acc;

  assign accept    = (state == ACCUM) && bus.in_valid && bus.in_ready;
  assign handoff   = (state == OUT) && bus.out_valid && bus.out_ready;
  assign mac_clear = (((state == IDLE) || (state == DONE)) && start) || handoff;

  // RELU only means something for two's complement results.
  always_comb begin
    post_acc = acc;
    if (RELU != 0 && SIGNED != 0) post_acc = ACC_W'(relu_fn(64'(acc), int'(ACC_W)));
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (mac_clear),
    .mul_en  (accept),
    .pixel   (bus.in_pixel),
    .weight  (bus.in_weight),
    .acc     (acc),
    .pending (pending)
  );

  // DRAIN waits until the product captured on the final accept has been
  // added, which puts out_valid two cycles after that accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tap_count     <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      out_count     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= ACCUM;
            tap_count    <= '0;
            bus.in_ready <= 1'b1;
            out_count    <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (tap_count == TAP_W'(TAPS - 1)) begin
              tap_count    <= '0;
              bus.in_ready <= 1'b0;
              state        <= DRAIN;
            end else begin
              tap_count <= tap_count + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!pending) begin
            state         <= OUT;
            bus.out_valid <= 1'b1;
            bus.out_data  <= post_acc;
            bus.out_last  <= (out_count == CNT_W'(NUM_OUT - 1));
          end
        end
        OUT: begin
          if (handoff) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            out_count     <= out_count + 1'b1;
            if (bus.out_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state        <= ACCUM;
              bus.in_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Bench for conv_window_mac. Four engines with NUM_OUT=3 share one stimulus
// stream (their handshake timing is data independent):
//   0: ACC_W=32 SAT=1 RELU=0   1: ACC_W=32 SAT=1 RELU=1
//   2: ACC_W=16 SAT=1 RELU=0   3: ACC_W=16 SAT=0 RELU=0
// A reference model turns every accepted pair into per-engine expected
// results that are queued and compared as each engine hands results off.
module tb_conv_window_mac;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_pixel;
  logic [7:0] in_weight;
  bit         rand_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       done_a, done_b, done_c, done_d;

  conv_window_mac_if #(.DATA_W(8), .ACC_W(32)) if_a ();
  conv_window_mac_if #(.DATA_W(8), .ACC_W(32)) if_b ();
  conv_window_mac_if #(.DATA_W(8), .ACC_W(16)) if_c ();
  conv_window_mac_if #(.DATA_W(8), .ACC_W(16)) if_d ();

  assign if_a.in_valid = in_valid;  assign if_a.in_pixel = in_pixel;
  assign if_a.in_weight = in_weight; assign if_a.out_ready = out_ready;
  assign if_b.in_valid = in_valid;  assign if_b.in_pixel = in_pixel;
  assign if_b.in_weight = in_weight; assign if_b.out_ready = out_ready;
  assign if_c.in_valid = in_valid;  assign if_c.in_pixel = in_pixel;
  assign if_c.in_weight = in_weight; assign if_c.out_ready = out_ready;
  assign if_d.in_valid = in_valid;  assign if_d.in_pixel = in_pixel;
  assign if_d.in_weight = in_weight; assign if_d.out_ready = out_ready;

  conv_window_mac #(.ACC_W(32), .NUM_OUT(3), .SAT(1), .RELU(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(if_a),
    .out_count(cnt_a), .busy(busy_a), .done(done_a));
  conv_window_mac #(.ACC_W(32), .NUM_OUT(3), .SAT(1), .RELU(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(if_b),
    .out_count(cnt_b), .busy(busy_b), .done(done_b));
  conv_window_mac #(.ACC_W(16), .NUM_OUT(3), .SAT(1), .RELU(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(if_c),
    .out_count(cnt_c), .busy(busy_c), .done(done_c));
  conv_window_mac #(.ACC_W(16), .NUM_OUT(3), .SAT(0), .RELU(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(if_d),
    .out_count(cnt_d), .busy(busy_d), .done(done_d));

  logic        o_val  [4];
  logic        o_last [4];
  logic [31:0] o_dat  [4];
  assign o_val[0] = if_a.out_valid; assign o_last[0] = if_a.out_last; assign o_dat[0] = if_a.out_data;
  assign o_val[1] = if_b.out_valid; assign o_last[1] = if_b.out_last; assign o_dat[1] = if_b.out_data;
  assign o_val[2] = if_c.out_valid; assign o_last[2] = if_c.out_last; assign o_dat[2] = 32'(if_c.out_data);
  assign o_val[3] = if_d.out_valid; assign o_last[3] = if_d.out_last; assign o_dat[3] = 32'(if_d.out_data);

  int cfg_w    [4] = '{32, 32, 16, 16};
  bit cfg_sat  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit cfg_relu [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  typedef logic [32:0] exp_t;   // {last, data}
  exp_t   exp_q [4][$];
  exp_t   exp_e;
  longint acc_m [4];
  longint prod_m;
  int     taps_m = 0;
  int     win_m  = 0;

  initial forever #5 clk = ~clk;

  // Watchdog so a wedged run still terminates.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Signed accumulate step, clamped or wrapped to w bits.
  function automatic longint mstep(input longint a, input longint p, input int w, input bit sat);
    longint s, hi, lo, m;
    s  = a + p;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    m  = (longint'(1) <<< w) - 1;
    if (sat) begin
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
    end else begin
      s = s & m;
      if (s > hi) s = s - (m + 1);
    end
    return s;
  endfunction

  function automatic logic [31:0] mpost(input longint a, input int w, input bit relu);
    longint m;
    m = (longint'(1) <<< w) - 1;
    if (relu && a < 0) a = 0;
    return 32'(a & m);
  endfunction

  // Scoreboard: model accepted pairs, compare each handed-off result.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 4; d++) begin
        acc_m[d] = 0;
        exp_q[d].delete();
      end
      taps_m = 0;
      win_m  = 0;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (o_val[d] && out_ready) begin
          if (exp_q[d].size() == 0) begin
            checkOutput($sformatf("unexpected_out%0d", d), 32'(o_val[d]), 32'd0);
          end else begin
            exp_e = exp_q[d].pop_front();
            checkOutput($sformatf("data%0d", d), o_dat[d], exp_e[31:0]);
            checkOutput($sformatf("last%0d", d), 32'(o_last[d]), 32'(exp_e[32]));
          end
        end
      end
      if (in_valid && if_a.in_ready) begin
        prod_m = longint'($signed(in_pixel)) * longint'($signed(in_weight));
        for (int d = 0; d < 4; d++) acc_m[d] = mstep(acc_m[d], prod_m, cfg_w[d], cfg_sat[d]);
        taps_m++;
        if (taps_m == 9) begin
          for (int d = 0; d < 4; d++) begin
            exp_q[d].push_back({(win_m == 2), mpost(acc_m[d], cfg_w[d], cfg_relu[d])});
            acc_m[d] = 0;
          end
          taps_m = 0;
          win_m  = (win_m == 2) ? 0 : win_m + 1;
        end
      end
    end
  end

  // Random or constant out_ready, updated just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Present one pair (optionally after an idle gap) and hold it until accepted.
  task automatic applyStimulus(input logic [7:0] p, input logic [7:0] w, input bit gap);
    int  cyc = 0;
    bit  ok  = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_pixel  = p;
    in_weight = w;
    in_valid  = 1'b1;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      ok = if_a.in_ready;
      cyc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) checkOutput("in_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic startRun();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDrain();
    int cyc = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) checkOutput("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b1;
    in_pixel  = 8'd7;
    in_weight = 8'd7;

    // Reset with in_valid high: everything quiet.
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready",  32'(if_a.in_ready),  32'd0);
    checkOutput("rst_out_valid", 32'(if_a.out_valid), 32'd0);
    checkOutput("rst_out_data",  if_a.out_data,       32'd0);
    checkOutput("rst_out_last",  32'(if_a.out_last),  32'd0);
    checkOutput("rst_out_count", 32'(cnt_a),          32'd0);
    checkOutput("rst_busy",      32'(busy_a),         32'd0);
    checkOutput("rst_done",      32'(done_a),         32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_busy",     32'(busy_a),        32'd0);
    checkOutput("idle_in_ready", 32'(if_a.in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Run 1, window 1: pixels 1..9, weights 1 -> 45, with latency checks.
    startRun();
    checkOutput("run_busy", 32'(busy_a), 32'd1);
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 8'd1, 1'b0);
    checkOutput("in_ready_drop", 32'(if_a.in_ready),  32'd0);
    checkOutput("lat_0",         32'(if_a.out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_1",         32'(if_a.out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_2",         32'(if_a.out_valid), 32'd1);
    waitDrain();
    checkOutput("count_after_1", 32'(cnt_a), 32'd1);

    // Window 2: -3 * 2 nine times (signed, RELU on engine 1).
    for (int i = 0; i < 9; i++) applyStimulus(8'hFD, 8'd2, 1'b0);
    waitDrain();

    // Window 3: 127 * 127 nine times (clamp vs wrap on 16-bit engines); last beat.
    for (int i = 0; i < 9; i++) applyStimulus(8'd127, 8'd127, 1'b0);
    waitDrain();
    checkOutput("run1_done",  32'(done_a), 32'd1);
    checkOutput("run1_busy",  32'(busy_a), 32'd0);
    checkOutput("run1_count", 32'(cnt_a),  32'd3);
    checkOutput("run1_done_d", 32'(done_d), 32'd1);

    // Run 2: random operands, input gaps, random out_ready.
    rand_ready = 1'b1;
    startRun();
    checkOutput("run2_count_clr", 32'(cnt_a),  32'd0);
    checkOutput("run2_done_clr",  32'(done_a), 32'd0);
    for (int i = 0; i < 27; i++)
      applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
    waitDrain();
    rand_ready = 1'b0;
    checkOutput("run2_done",  32'(done_a), 32'd1);
    checkOutput("run2_count", 32'(cnt_a),  32'd3);

    // Extra input after the run must be ignored.
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("ignored_in_ready",  32'(if_a.in_ready),  32'd0);
      checkOutput("ignored_out_valid", 32'(if_a.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Run 3: reset after 4 taps, restart, stray start mid-window.
    startRun();
    for (int i = 0; i < 4; i++) applyStimulus(8'd50, 8'd50, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy",      32'(busy_a),         32'd0);
    checkOutput("midrst_out_valid", 32'(if_a.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    startRun();
    for (int i = 1; i <= 2; i++) applyStimulus(8'(i), 8'd3, 1'b0);
    startRun();
    checkOutput("stray_start_busy",  32'(busy_a),        32'd1);
    checkOutput("stray_start_ready", 32'(if_a.in_ready), 32'd1);
    for (int i = 3; i <= 9; i++) applyStimulus(8'(i), 8'd3, 1'b0);
    waitDrain();
    checkOutput("run3_count", 32'(cnt_a), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
